// File: rtl/up_cmd_master.sv
// Command-to-UP bridge: turns one command handshake into a single UP read or write
// request, waits for the matching ack (bounded by a timeout) and returns one response.
module up_cmd_master #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstn,

    input  logic                     s_cmd_valid,
    output logic                     s_cmd_ready,
    input  logic                     s_cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] s_cmd_addr,
    input  logic [BUS_WIDTH*8-1:0]   s_cmd_wdata,

    output logic                     m_rsp_valid,
    input  logic                     m_rsp_ready,
    output logic                     m_rsp_we,
    output logic                     m_rsp_err,
    output logic [BUS_WIDTH*8-1:0]   m_rsp_rdata,

    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic                     up_rack,
    input  logic [BUS_WIDTH*8-1:0]   up_rdata,

    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [BUS_WIDTH*8-1:0]   up_wdata,
    input  logic                     up_wack,

    output logic                     busy
);

    localparam int unsigned DATA_W = BUS_WIDTH * 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     cmd_we_q, cmd_we_d;
    logic [ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]        cmd_wdata_q, cmd_wdata_d;

    logic                     rsp_we_q, rsp_we_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]        rsp_rdata_q, rsp_rdata_d;

    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     busy_q, busy_d;
    logic                     up_rreq_q, up_rreq_d;
    logic                     up_wreq_q, up_wreq_d;
    logic [ADDRESS_WIDTH-1:0] up_raddr_q, up_raddr_d;
    logic [ADDRESS_WIDTH-1:0] up_waddr_q, up_waddr_d;
    logic [DATA_W-1:0]        up_wdata_q, up_wdata_d;

    logic                     ack_hit;

    // Next-state, captured command/response and registered output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        ack_hit     = cmd_we_q ? up_wack : up_rack;

        case (state_q)
            IDLE: begin
                if (s_cmd_valid && cmd_ready_q) begin
                    cmd_we_d    = s_cmd_we;
                    cmd_addr_d  = s_cmd_addr;
                    cmd_wdata_d = s_cmd_wdata;
                    state_d     = REQ;
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A matching ack takes priority over the timeout in the final cycle
                if (ack_hit) begin
                    rsp_we_d    = cmd_we_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = cmd_we_q ? '0 : up_rdata;
                    state_d     = RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_we_d    = cmd_we_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RSP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RSP: begin
                if (m_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RSP);
        up_wreq_d   = (state_d == REQ) &&  cmd_we_d;
        up_rreq_d   = (state_d == REQ) && !cmd_we_d;
        up_waddr_d  = up_wreq_d ? cmd_addr_d  : '0;
        up_wdata_d  = up_wreq_d ? cmd_wdata_d : '0;
        up_raddr_d  = up_rreq_d ? cmd_addr_d  : '0;
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            up_rreq_q   <= 1'b0;
            up_wreq_q   <= 1'b0;
            up_raddr_q  <= '0;
            up_waddr_q  <= '0;
            up_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            up_rreq_q   <= up_rreq_d;
            up_wreq_q   <= up_wreq_d;
            up_raddr_q  <= up_raddr_d;
            up_waddr_q  <= up_waddr_d;
            up_wdata_q  <= up_wdata_d;
        end
    end

    assign s_cmd_ready = cmd_ready_q;
    assign m_rsp_valid = rsp_valid_q;
    assign m_rsp_we    = rsp_we_q;
    assign m_rsp_err   = rsp_err_q;
    assign m_rsp_rdata = rsp_rdata_q;
    assign up_rreq     = up_rreq_q;
    assign up_raddr    = up_raddr_q;
    assign up_wreq     = up_wreq_q;
    assign up_waddr    = up_waddr_q;
    assign up_wdata    = up_wdata_q;
    assign busy        = busy_q;

endmodule

// File: doc/up_cmd_master.md
UP_CMD_MASTER -- requirements
Module: up_cmd_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, SHALL set the width of the command address and the UP addresses.
REQ-002 Parameter BUS_WIDTH, default 4, SHALL set the data width in bytes; the data width is BUS_WIDTH*8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1-65535, SHALL set the maximum number of cycles the block waits for an ack.
REQ-004 clk  in  1  SHALL be the clock; all logic is rising-edge.
REQ-005 rstn  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 s_cmd_valid/s_cmd_ready  in/out  1/1  SHALL form the command handshake.
REQ-007 s_cmd_we  in  1  SHALL select the operation: 1 = write, 0 = read.
REQ-008 s_cmd_addr, s_cmd_wdata  in  ADDRESS_WIDTH, BUS_WIDTH*8  SHALL carry the command address and the write data.
REQ-009 m_rsp_valid/m_rsp_ready  out/in  1/1  SHALL form the response handshake.
REQ-010 m_rsp_we, m_rsp_err, m_rsp_rdata  out  1, 1, BUS_WIDTH*8  SHALL return the operation echo, the timeout flag and the read data.
REQ-011 up_rreq, up_raddr  out  1, ADDRESS_WIDTH  SHALL be the UP read request.
REQ-012 up_rack, up_rdata  in  1, BUS_WIDTH*8  SHALL be the UP read acknowledge and the read data.
REQ-013 up_wreq, up_waddr, up_wdata  out  1, ADDRESS_WIDTH, BUS_WIDTH*8  SHALL be the UP write request.
REQ-014 up_wack  in  1  SHALL be the UP write acknowledge.
REQ-015 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and RSP.
REQ-017 In IDLE, s_cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 When s_cmd_valid and s_cmd_ready are both high, the block SHALL register we, addr and wdata and move to REQ.
REQ-019 REQ SHALL last one cycle and drive either up_wreq=1 with up_waddr/up_wdata, or up_rreq=1 with up_raddr; the block SHALL then move to WAIT with the timeout counter at 0.
REQ-020 Outside REQ, up_rreq and up_wreq SHALL be 0 and up_raddr, up_waddr and up_wdata SHALL be 0.
REQ-021 The block SHALL sample the ack only in WAIT: up_wack for writes, up_rack for reads.
REQ-022 An ack of the wrong type, or any ack seen in IDLE, REQ or RSP, SHALL be ignored.
REQ-023 On a matching ack in WAIT, the block SHALL register rsp_err=0 and, for reads, rsp_rdata=up_rdata from that cycle (0 for writes), then move to RSP.
REQ-024 Each WAIT cycle without an ack SHALL increment the counter.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 with no ack, the block SHALL move to RSP with rsp_err=1 and rsp_rdata=0.
REQ-026 An ack arriving in that same final cycle SHALL win: err=0.
REQ-027 In RSP, m_rsp_valid SHALL be 1 and all m_rsp_* signals SHALL be held stable until m_rsp_ready is high; the block SHALL then return to IDLE in the next cycle.
REQ-028 In RSP, m_rsp_ready held low SHALL stall the block indefinitely, and no new request SHALL be issued.
REQ-029 Latency: command accepted in cycle N -> request in N+1 -> earliest ack sampled in N+2 -> m_rsp_valid in N+3.
REQ-030 Minimum spacing SHALL be 4 cycles per transaction.
REQ-031 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, SHALL saturate (never wrap), and SHALL clear on entry to WAIT.
REQ-032 Only one transaction SHALL be outstanding at any time.

Reset
REQ-033 While rstn=0 at a clock edge, the state SHALL become IDLE and the counter 0.
REQ-034 During reset, s_cmd_ready=0, m_rsp_valid=0, m_rsp_we=0, m_rsp_err=0, m_rsp_rdata=0, all up_* outputs=0 and busy=0.
REQ-035 s_cmd_ready SHALL rise in the first cycle after rstn returns high.
REQ-036 Reset applied mid-transaction SHALL abort it with no response; a later ack SHALL be ignored.

Verification
REQ-037 Write: cmd we=1, addr 0x004, wdata 0xFFFFFFFF; responder acks 1 cycle after the request -> one up_wreq pulse with up_waddr=0x004 and up_wdata=0xFFFFFFFF; response we=1, err=0, rdata=0; m_rsp_valid in N+3.
REQ-038 Read: cmd we=0, addr 0x000; responder returns up_rdata=0xDEADBEEF with rack 3 cycles late -> response rdata=0xDEADBEEF, err=0.
REQ-039 Timeout: TIMEOUT_CYCLES=8, no ack -> exactly one request pulse; response err=1, rdata=0 after 8 WAIT cycles; a stray wack arriving afterwards is ignored.
REQ-040 Backpressure: m_rsp_ready low for 10 cycles with s_cmd_valid held high -> response stable, s_cmd_ready=0, no new up_*req until the handshake completes.
REQ-041 Wrong ack: read in WAIT receives up_wack only, then up_rack 2 cycles later -> response from the rack, err=0.
REQ-042 Reset asserted in WAIT, then rack -> no m_rsp_valid; s_cmd_ready=1 one cycle after rstn returns high.
